// File: rtl/bus_bridge_ic_if.sv
// -----------------------------------------------------------------------------
// bus_bridge_ic_if
// CPU-side request/response bus of the timer/interrupt bridge.
//   cpu_addr   : byte address (bits [1:0] ignored by the bridge)
//   cpu_wdata  : write data
//   cpu_we     : write request strobe
//   cpu_re     : read request strobe
//   cpu_rdata  : read data, non-zero only while cpu_ready is high
//   cpu_ready  : one-cycle completion pulse
//   cpu_err    : completion with an unmapped address
// master = CPU side, slave = bridge side.
// -----------------------------------------------------------------------------
interface bus_bridge_ic_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  cpu_rdata, cpu_ready, cpu_err
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output cpu_rdata, cpu_ready, cpu_err
  );
endinterface

// File: rtl/bus_bridge_ic.sv
// -----------------------------------------------------------------------------
// bus_bridge_ic
// Bridges a simple CPU strobe bus to two timer devices and a small interrupt
// controller. Every transaction takes three cycles: IDLE (request latched),
// ACCESS (device strobes / register update / read capture), DONE (cpu_ready).
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   cpu                   : CPU bus (bus_bridge_ic_if.slave)
//   PrAddr, PrWD          : device register select and write data (held)
//   we0, we1              : device write enables, high only in ACCESS
//   rd0, rd1              : device read data, combinational on PrAddr
//   irq0, irq1, ext_irq   : level interrupt sources
//   cpu_irq               : registered interrupt request to the CPU
// Interrupt controller at IC_BASE: +0 PENDING (W1C), +4 MASK (RW), +8 STATUS.
// -----------------------------------------------------------------------------
module bus_bridge_ic #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IC_BASE   = 32'h0000_7F20
) (
  input  logic           clk,
  input  logic           reset,
  bus_bridge_ic_if.slave cpu,
  output logic [3:2]     PrAddr,
  output logic [31:0]    PrWD,
  output logic           we0,
  output logic           we1,
  input  logic [31:0]    rd0,
  input  logic [31:0]    rd1,
  input  logic           irq0,
  input  logic           irq1,
  input  logic           ext_irq,
  output logic           cpu_irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;
  logic        we0_r;
  logic        we1_r;
  logic        ready_r;
  logic        err_r;
  logic [31:0] rdata_r;

  logic [2:0]  src_s;
  logic [2:0]  hist_r;
  logic [2:0]  edge_s;
  logic [2:0]  pending_r;
  logic [2:0]  mask_r;
  logic [2:0]  pend_clr_s;
  logic [2:0]  pend_nxt_s;
  logic [2:0]  mask_nxt_s;
  logic        ic_wr_s;
  logic        cpu_irq_r;

  logic        hit0_s;
  logic        hit1_s;
  logic        hitic_s;
  logic        mapped_s;
  logic [1:0]  ic_off_s;
  logic        req_hit0_s;
  logic        req_hit1_s;
  logic [31:0] rd_mux_s;

  // A window is words 0..2 above its base; word 3 is a hole.
  function automatic logic win_hit_f(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = {addr[31:2], 2'b00} - base;
    return (off[31:4] == 28'd0) && (off[3:2] != 2'b11);
  endfunction

  // Word index of an address inside a window.
  function automatic logic [1:0] win_off_f(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = {addr[31:2], 2'b00} - base;
    return off[3:2];
  endfunction

  // Address decode of the latched and incoming address, plus read-data mux.
  always_comb begin
    hit0_s     = win_hit_f(addr_r, DEV0_BASE);
    hit1_s     = win_hit_f(addr_r, DEV1_BASE);
    hitic_s    = win_hit_f(addr_r, IC_BASE);
    mapped_s   = hit0_s | hit1_s | hitic_s;
    ic_off_s   = win_off_f(addr_r, IC_BASE);
    req_hit0_s = win_hit_f(cpu.cpu_addr, DEV0_BASE);
    req_hit1_s = win_hit_f(cpu.cpu_addr, DEV1_BASE) & ~req_hit0_s;
    rd_mux_s   = 32'd0;
    if (hit0_s) begin
      rd_mux_s = rd0;
    end else if (hit1_s) begin
      rd_mux_s = rd1;
    end else if (hitic_s) begin
      case (ic_off_s)
        2'd0:    rd_mux_s = {29'd0, pending_r};
        2'd1:    rd_mux_s = {29'd0, mask_r};
        2'd2:    rd_mux_s = {29'd0, src_s};
        default: rd_mux_s = 32'd0;
      endcase
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // Transaction FSM with registered bus and device outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      we_r    <= 1'b0;
      we0_r   <= 1'b0;
      we1_r   <= 1'b0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
          if (cpu.cpu_we | cpu.cpu_re) begin
            // The write enable is registered here so it is high exactly in ACCESS.
            addr_r  <= cpu.cpu_addr;
            wdata_r <= cpu.cpu_wdata;
            we_r    <= cpu.cpu_we;
            we0_r   <= cpu.cpu_we & req_hit0_s;
            we1_r   <= cpu.cpu_we & req_hit1_s;
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          we0_r   <= 1'b0;
          we1_r   <= 1'b0;
          ready_r <= 1'b1;
          err_r   <= ~mapped_s;
          rdata_r <= (we_r | ~mapped_s) ? 32'd0 : rd_mux_s;
          state_r <= DONE;
        end
        DONE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
          state_r <= IDLE;
        end
        default: begin
          we0_r   <= 1'b0;
          we1_r   <= 1'b0;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Interrupt controller next-state: edge detect, W1C clear, mask write.
  always_comb begin
    src_s      = {ext_irq, irq1, irq0};
    edge_s     = src_s & ~hist_r;
    ic_wr_s    = (state_r == ACCESS) && we_r && hitic_s;
    pend_clr_s = (ic_wr_s && (ic_off_s == 2'd0)) ? wdata_r[2:0] : 3'b000;
    mask_nxt_s = (ic_wr_s && (ic_off_s == 2'd1)) ? wdata_r[2:0] : mask_r;
    // A new edge is OR-ed in after the clear so it survives a same-cycle clear.
    pend_nxt_s = (pending_r & ~pend_clr_s) | edge_s;
  end

  // Interrupt controller state and registered CPU interrupt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_r    <= 3'b000;
      pending_r <= 3'b000;
      mask_r    <= 3'b000;
      cpu_irq_r <= 1'b0;
    end else begin
      hist_r    <= src_s;
      pending_r <= pend_nxt_s;
      mask_r    <= mask_nxt_s;
      cpu_irq_r <= |(pending_r & mask_r);
    end
  end

  assign cpu.cpu_rdata = rdata_r;
  assign cpu.cpu_ready = ready_r;
  assign cpu.cpu_err   = err_r;
  assign PrAddr        = addr_r[3:2];
  assign PrWD          = wdata_r;
  // Reset masks the strobes at once so an abandoned ACCESS never shows a write.
  assign we0           = we0_r & reset;
  assign we1           = we1_r & reset;
  assign cpu_irq       = cpu_irq_r;

endmodule

// File: tb/tb_bus_bridge_ic.sv
// -----------------------------------------------------------------------------
// tb_bus_bridge_ic
// Table of CPU transactions with expected device strobes, plus hand-written
// sequences for interrupt timing, same-cycle edge/clear and mid-access reset.
// Expected completions go into a queue and are popped when cpu_ready shows.
// -----------------------------------------------------------------------------
module tb_bus_bridge_ic;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        err;
    logic [31:0] rdata;
    logic        we0;
    logic        we1;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:2]  PrAddr;
  logic [31:0] PrWD;
  logic        we0;
  logic        we1;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic        irq0;
  logic        irq1;
  logic        ext_irq;
  logic        cpu_irq;

  bus_bridge_ic_if bus ();

  bus_bridge_ic dut (
    .clk     (clk),
    .reset   (reset),
    .cpu     (bus),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .we0     (we0),
    .we1     (we1),
    .rd0     (rd0),
    .rd1     (rd1),
    .irq0    (irq0),
    .irq1    (irq1),
    .ext_irq (ext_irq),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  int   n_cmp    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t rd_v(input logic [31:0] addr, input logic [31:0] exp);
    vec_t v;
    v = '{1'b0, 1'b1, addr, 32'h0, 32'h0, 32'h0, 1'b0, exp, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic vec_t wr_v(input logic [31:0] addr, input logic [31:0] data);
    vec_t v;
    v = '{1'b1, 1'b0, addr, data, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    return v;
  endfunction

  // Scoreboard: every completion pops one expectation; idle cycles must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cpu_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ready: got cpu_ready=1 expected no completion at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("cpu_err", {31'd0, bus.cpu_err}, {31'd0, mon_e.err});
          check("cpu_rdata", bus.cpu_rdata, mon_e.rdata);
        end
        done_cnt++;
      end else begin
        check("idle_rdata", bus.cpu_rdata, 32'd0);
        check("idle_err", {31'd0, bus.cpu_err}, 32'd0);
      end
    end
  end

  task automatic run_txn(input vec_t v, input string nm, input bit irq1_mid);
    int start;
    bit seen;
    @(negedge clk);
    bus.cpu_we    = v.we;
    bus.cpu_re    = v.re;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    rd0           = v.rd0;
    rd1           = v.rd1;
    sb_q.push_back('{err: v.err, rdata: v.rdata});
    start = done_cnt;
    @(posedge clk);
    #1;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = 32'hFFFF_FFFF;
    bus.cpu_wdata = 32'h0;
    if (irq1_mid) irq1 = 1'b1;
    @(negedge clk);
    check({nm, "_we0"}, {31'd0, we0}, {31'd0, v.we0});
    check({nm, "_we1"}, {31'd0, we1}, {31'd0, v.we1});
    check({nm, "_praddr"}, {30'd0, PrAddr}, {30'd0, v.addr[3:2]});
    check({nm, "_ready_access"}, {31'd0, bus.cpu_ready}, 32'd0);
    if (v.we) check({nm, "_prwd"}, PrWD, v.wdata);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no cpu_ready expected one within 6 cycles", nm);
    end
    #1;
    check({nm, "_we0_after"}, {31'd0, we0}, 32'd0);
    check({nm, "_praddr_hold"}, {30'd0, PrAddr}, {30'd0, v.addr[3:2]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_7F04, 32'h0000_0064, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_7F18, 32'h0, 32'h0, 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_7F0C, 32'h0, 32'h0BAD_0BAD, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_7F00, 32'h0, 32'hAAAA_5555, 32'h1, 1'b0, 32'hAAAA_5555, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_7F18, 32'h0000_DEAD, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_7F1C, 32'h0, 32'h0, 32'h0000_0099, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_7F24, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_7F24, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_7F28, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_7F28, 32'h0000_0007, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_7F2C, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_7F03, 32'h0000_0011, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_7F08, 32'h0000_0022, 32'h7, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_7EFC, 32'h0, 32'h0000_0005, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_7F24, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h0000_7F24, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_7F14, 32'h0, 32'h0, 32'h0000_CAFE, 1'b0, 32'h0000_CAFE, 1'b0, 1'b0};

    reset         = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    rd0           = 32'h0;
    rd1           = 32'h0;
    irq0          = 1'b0;
    irq1          = 1'b0;
    ext_irq       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
    check("rst_err", {31'd0, bus.cpu_err}, 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_praddr", {30'd0, PrAddr}, 32'd0);
    check("rst_prwd", PrWD, 32'd0);
    check("rst_we", {30'd0, we1, we0}, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Masked irq0 edge reaches cpu_irq one cycle after PENDING sets.
    run_txn(wr_v(32'h0000_7F24, 32'h1), "mask1", 1'b0);
    @(negedge clk);
    irq0 = 1'b1;
    @(negedge clk);
    check("irq_not_yet", {31'd0, cpu_irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, cpu_irq}, 32'd1);
    run_txn(rd_v(32'h0000_7F20, 32'h1), "pend_rd", 1'b0);
    run_txn(wr_v(32'h0000_7F20, 32'h1), "pend_clr", 1'b0);
    @(negedge clk);
    check("irq_cleared", {31'd0, cpu_irq}, 32'd0);
    repeat (3) @(negedge clk);
    check("irq_held_high", {31'd0, cpu_irq}, 32'd0);
    run_txn(rd_v(32'h0000_7F20, 32'h0), "pend_held", 1'b0);

    // Unmasked ext_irq pends without raising cpu_irq; STATUS shows levels.
    @(negedge clk);
    ext_irq = 1'b1;
    repeat (2) @(negedge clk);
    check("ext_masked", {31'd0, cpu_irq}, 32'd0);
    run_txn(rd_v(32'h0000_7F20, 32'h4), "pend_ext", 1'b0);
    run_txn(rd_v(32'h0000_7F28, 32'h5), "status", 1'b0);
    run_txn(wr_v(32'h0000_7F20, 32'h7), "pend_clr_all", 1'b0);
    run_txn(rd_v(32'h0000_7F20, 32'h0), "pend_empty", 1'b0);
    @(negedge clk);
    irq0    = 1'b0;
    ext_irq = 1'b0;

    // irq1 rises in the ACCESS cycle of a PENDING clear of that bit.
    run_txn(wr_v(32'h0000_7F20, 32'h2), "race_wr", 1'b1);
    run_txn(rd_v(32'h0000_7F20, 32'h2), "race_rd", 1'b0);
    run_txn(wr_v(32'h0000_7F20, 32'h2), "race_clr", 1'b0);
    run_txn(rd_v(32'h0000_7F20, 32'h0), "race_empty", 1'b0);
    @(negedge clk);
    irq1 = 1'b0;

    // Reset during ACCESS of a write abandons it.
    @(negedge clk);
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0000_7F04;
    bus.cpu_wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    bus.cpu_we = 1'b0;
    reset      = 1'b0;
    irq0       = 1'b1;
    @(negedge clk);
    check("abort_we", {30'd0, we1, we0}, 32'd0);
    check("abort_ready", {31'd0, bus.cpu_ready}, 32'd0);
    @(negedge clk);
    check("abort_ready2", {31'd0, bus.cpu_ready}, 32'd0);
    check("abort_praddr", {30'd0, PrAddr}, 32'd0);
    check("abort_prwd", PrWD, 32'd0);
    check("abort_we2", {30'd0, we1, we0}, 32'd0);
    check("abort_irq", {31'd0, cpu_irq}, 32'd0);
    reset = 1'b1;
    // irq0 already high at release counts as an edge; MASK is back to 0.
    run_txn(rd_v(32'h0000_7F20, 32'h1), "rel_edge", 1'b0);
    run_txn(rd_v(32'h0000_7F24, 32'h0), "rel_mask", 1'b0);
    check("rel_irq", {31'd0, cpu_irq}, 32'd0);
    run_txn(vecs[1], "post_reset", 1'b0);
    irq0 = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_bridge_ic.md
BUS_BRIDGE_IC -- requirements
Module: bus_bridge_ic

Interface
REQ-001 SHALL have parameter DEV0_BASE, default 32'h0000_7F00, base of timer device 0 (12-byte window).
REQ-002 SHALL have parameter DEV1_BASE, default 32'h0000_7F10, base of timer device 1 (12-byte window).
REQ-003 SHALL have parameter IC_BASE, default 32'h0000_7F20: +0 PENDING (W1C), +4 MASK (RW), +8 STATUS (RO).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port cpu_addr, input, 32, byte address; bits [1:0] ignored.
REQ-007 SHALL have port cpu_wdata, input, 32, write data.
REQ-008 SHALL have ports cpu_we and cpu_re, input, 1 each, request strobes.
REQ-009 SHALL have port cpu_rdata, output, 32, read data, valid only while cpu_ready=1.
REQ-010 SHALL have port cpu_ready, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port cpu_err, output, 1, high with cpu_ready for an unmapped address.
REQ-012 SHALL have port cpu_irq, output, 1, registered interrupt to the CPU.
REQ-013 SHALL have ports PrAddr [3:2], PrWD [31:0], output, device register select and write data.
REQ-014 SHALL have ports we0 and we1, output, 1 each, device write enables.
REQ-015 SHALL have ports rd0 and rd1, input, 32 each, device read data (combinational on PrAddr).
REQ-016 SHALL have ports irq0, irq1, ext_irq, input, 1 each, level interrupt sources.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, one transaction per 3 cycles.
REQ-018 In IDLE, cpu_we|cpu_re SHALL latch address, wdata, direction; cpu_we wins if both high.
REQ-019 Requests are ignored outside IDLE; cpu_we/cpu_re SHALL be sampled only in IDLE.
REQ-020 In ACCESS, PrAddr/PrWD SHALL be driven from the latch; we0/we1 SHALL pulse exactly this cycle for a write hit.
REQ-021 Decode: hit = addr in [BASE, BASE+8] word-aligned; word offset 3 (BASE+12) SHALL be unmapped.
REQ-022 In ACCESS, read data (rd0, rd1 or IC register) SHALL be registered into cpu_rdata.
REQ-023 In DONE, cpu_ready=1 for one cycle; cpu_err=1 and cpu_rdata=0 if unmapped; an unmapped write has no side effect.
REQ-024 Outside DONE, cpu_ready=0, cpu_err=0, cpu_rdata=0.
REQ-025 PrAddr and PrWD SHALL hold last values when not in ACCESS; we0=we1=0 outside ACCESS.
REQ-026 Sources [2:0] = {ext_irq, irq1, irq0}; each SHALL be rising-edge detected against a 1-flop history register.
REQ-027 A rising edge SHALL set PENDING[i]; PENDING[31:3] read 0.
REQ-028 A PENDING write (ACCESS cycle) SHALL clear bits where wdata=1; a same-cycle edge on that bit SHALL win (bit stays 1).
REQ-029 MASK[2:0] SHALL be RW; MASK[31:3] read 0.
REQ-030 STATUS SHALL read {29'b0, irq source levels}; writes SHALL be ignored but still complete normally.
REQ-031 cpu_irq SHALL be the register of |(PENDING & MASK), i.e. one cycle after the pending/mask update.
REQ-032 A source held high SHALL NOT re-set PENDING after clear until it falls and rises again.

Reset
REQ-033 On reset=0 at a clock edge: FSM=IDLE, PENDING=0, MASK=0, edge history=0, cpu_irq=0, cpu_ready=0, cpu_err=0, cpu_rdata=0, PrAddr=0, PrWD=0, we0=we1=0.
REQ-034 Reset mid-transaction SHALL abandon it: no we pulse, no cpu_ready.
REQ-035 Edge history reset to 0 SHALL make a source high at reset release register as an edge on the first cycle.

Verification
REQ-036 Write 0x7F04 data 0x64 -> we0=1, PrAddr=2'b01, PrWD=0x64 in ACCESS; cpu_ready at cycle 3; we1 never high.
REQ-037 Read 0x7F18 with rd1=0x1234 -> cpu_rdata=0x1234 with cpu_ready, cpu_err=0.
REQ-038 Read 0x7F0C and write 0x8000 -> cpu_ready=1, cpu_err=1, cpu_rdata=0, no we pulse.
REQ-039 MASK=0x1, irq0 0->1 -> PENDING=0x1, cpu_irq=1 next cycle; write PENDING 0x1 -> cpu_irq=0; irq0 held high -> stays 0.
REQ-040 irq1 rises in the same cycle as a PENDING write of 0x2 -> PENDING[1]=1 afterwards.
REQ-041 Assert reset during ACCESS of a write -> no we pulse, no cpu_ready, all outputs at reset values next cycle.
